seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Upstream driver for the per-digit 7-segment decoder on the Basys3 board.
- Time-multiplexes a 16-bit value onto the board's four common-anode digits.
- Selects one of four 16-bit debug pages (e.g. PC / next PC, register data) using a debounced push-button.
- Emits the current 4-bit nibble and the active-low anode enables. The decoder converts the nibble to segment code.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range >= 2
BLANK_CYCLES, 4, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 .. REFRESH_DIV-1
DEBOUNCE_CYCLES, 1000000, cycles the synchronized button must hold a new level before it is accepted; legal range >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
page0  in  16  display page 0
page1  in  16  display page 1
page2  in  16  display page 2
page3  in  16  display page 3
btn_page  in  1  raw push-button, asynchronous, active-high
page_sel  out  2  currently selected page
digit_data  out  4  nibble for the decoder
an  out  4  anode enables, active-low, an[0] = rightmost digit

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is synchronous and active-low: sampled only on the rising edge of clk, and the design resets while rst_n = 0.
- Reset values:
  - page_sel = 0, digit_data = 0, an = 4'b1111.
  - Refresh counter = 0, digit index = 0, shadow register = 0.
  - Debounce counter = 0, debounced level = 0, synchronizer flops = 0.
- Reset asserted mid-operation restores all of the above on the next edge. No partial state survives.
- Button path:
  - btn_page passes through a 2-flop synchronizer.
  - Debounce counter clears whenever the synchronized level equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level takes the synchronized level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Page select:
  - A 0->1 transition of the debounced level increments page_sel modulo 4 (3 -> 0).
  - Holding the button gives exactly one increment; release plus a new press is required for the next one.
- Refresh counter:
  - Counts 0 .. REFRESH_DIV-1, then wraps to 0.
  - On wrap, the digit index advances 0->1->2->3->0.
- Shadow latch (frame-atomic update):
  - When the digit index advances from 3 to 0, the shadow register loads page[page_sel] as sampled on that same edge.
  - A page change or page-data change therefore appears only at the next frame boundary. A frame never mixes two values.
  - The first frame after reset displays 0000.
- Outputs (registered, both follow the digit index with one cycle latency):
  - digit_data = shadow[4*idx+3 : 4*idx], i.e. idx 0 -> bits [3:0] on the rightmost digit.
  - an = one-hot-low of idx (idx 0 -> 4'b1110, idx 3 -> 4'b0111).
  - an is forced to 4'b1111 while the refresh counter < BLANK_CYCLES.
  - With BLANK_CYCLES = 0, no blanking occurs.
  - digit_data is valid for the entire slot, including blank cycles.
- Simultaneous events:
  - A page increment on the same edge as a 3->0 wrap: the shadow loads the old page_sel value (the pre-edge register). The new page shows one frame later.
  - Page data changing on the latch edge: the value sampled on that edge is captured.
- No handshake. The outputs are free-running whenever rst_n = 1.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=1, DEBOUNCE_CYCLES=4):
1. Reset:
   - Stimulus: rst_n=0 for 3 cycles, release.
   - Required: page_sel=0, an=1111, digit_data=0 during reset; first frame shows 0000.
   - Then an cycles 1110, 1101, 1011, 0111, each held 7 cycles after 1 blank cycle per 8-cycle slot.
2. Scan order:
   - Stimulus: page0=16'h1A3F, wait one full frame.
   - Required: the next frame shows digit_data F, 3, A, 1 with an 1110, 1101, 1011, 0111 respectively.
3. Debounce:
   - Stimulus: btn_page pulses high for 2 cycles.
   - Required: page_sel stays 0.
   - Stimulus: btn held high 20 cycles.
   - Required: page_sel=1 exactly once. Release, press again: page_sel=2; repeat twice more, wrapping 3->0.
4. Frame atomicity:
   - Stimulus: page0=16'h1234, page1=16'hABCD; press the button mid-frame.
   - Required: the remainder of the current frame and the next frame still show 1234; the frame after shows ABCD, and no frame mixes digits.
5. Mid-scan reset:
   - Stimulus: assert rst_n=0 during digit slot 2 for 1 cycle.
   - Required: next edge an=1111, idx=0, page_sel=0, shadow=0; the scan restarts at digit 0.
6. Data change on latch edge:
   - Stimulus: change page0 from 16'h0000 to 16'hFFFF on exactly the 3->0 wrap edge.
   - Required: the following frame shows FFFF.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scans one of four 16-bit debug pages onto a 4-digit common-anode display
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   page0..3   16-bit display pages
//   btn_page   raw asynchronous push-button, each accepted press advances page_sel
//   page_sel   currently selected page
//   digit_data nibble for the downstream segment decoder
//   an         active-low anode enables, an[0] = rightmost digit
module seg_scan_ctrl #(
  parameter int REFRESH_DIV     = 100000,
  parameter int BLANK_CYCLES    = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] page0,
  input  logic [15:0] page1,
  input  logic [15:0] page2,
  input  logic [15:0] page3,
  input  logic        btn_page,
  output logic [1:0]  page_sel,
  output logic [3:0]  digit_data,
  output logic [3:0]  an
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync;
  logic          db_lvl;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   cur_page;
  logic          wrap, blank;
  logic [3:0]    nib;
  always_comb begin
    cur_page = page_sel[1] ? (page_sel[0] ? page3 : page2) : (page_sel[0] ? page1 : page0);
    wrap     = rcnt == RW'(REFRESH_DIV - 1);
    blank    = 32'(rcnt) < BLANK_CYCLES;
    nib      = 4'(shadow >> {idx, 2'b00});
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync       <= '0;
      db_lvl     <= 1'b0;
      dcnt       <= '0;
      page_sel   <= '0;
      rcnt       <= '0;
      idx        <= '0;
      shadow     <= '0;
      digit_data <= '0;
      an         <= 4'hF;
    end else begin
      sync <= {sync[0], btn_page};
      // sync[1] is the synchronized level; it must differ from db_lvl for DEBOUNCE_CYCLES edges
      if (sync[1] == db_lvl)
        dcnt <= '0;
      else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        dcnt   <= '0;
        db_lvl <= sync[1];
        if (sync[1])
          page_sel <= page_sel + 2'd1;
      end else
        dcnt <= dcnt + 1'b1;
      rcnt <= wrap ? '0 : rcnt + 1'b1;
      if (wrap)
        idx <= idx + 2'd1;
      // frame boundary: capture with the pre-edge page_sel so a frame never mixes two pages
      if (wrap && idx == 2'd3)
        shadow <= cur_page;
      digit_data <= nib;
      an         <= blank ? 4'hF : ~(4'b0001 << idx);
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl (REFRESH_DIV=8, BLANK_CYCLES=1, DEBOUNCE_CYCLES=4)
module tb_seg_scan_ctrl;
  localparam int RD = 8, BC = 1, DC = 4, FR = 4 * RD;
  logic        clk = 1'b0, rst_n = 1'b0, btn = 1'b0;
  logic [15:0] pg [4];
  logic [1:0]  page_sel;
  logic [3:0]  digit_data, an;
  typedef struct packed { logic [1:0] sel; logic [3:0] dig; logic [3:0] an; } out_t;
  typedef struct packed { logic [15:0] p; logic [15:0] dig; } vec_t;
  out_t        q[$];
  vec_t        tbl [4];
  logic [15:0] an_seq = 16'hEDB7;
  int          t = 0, cyc = 0, pend = -1, vecs = 0, errs = 0;
  logic [1:0]  m_sel = 2'd0;
  logic [15:0] m_shadow = 16'h0;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .page0(pg[0]), .page1(pg[1]), .page2(pg[2]), .page3(pg[3]),
    .btn_page(btn), .page_sel(page_sel), .digit_data(digit_data), .an(an)
  );

  always #5 clk = ~clk;

  // Reference: t counts edges since reset release, so slot = t % RD and digit = (t / RD) % 4.
  // Outputs after an edge reflect the state before it; pend marks the edge a press is accepted.
  always @(posedge clk) begin
    out_t e;
    if (!rst_n) begin
      e = '{2'd0, 4'd0, 4'hF};
      t = 0; m_sel = 2'd0; m_shadow = 16'h0; pend = -1;
    end else begin
      e.an  = (t % RD < BC) ? 4'hF : 4'(~(4'b0001 << ((t / RD) % 4)));
      e.dig = 4'(m_shadow >> (4 * ((t / RD) % 4)));
      if (t % FR == FR - 1) m_shadow = pg[m_sel];
      if (cyc == pend) m_sel = m_sel + 2'd1;
      e.sel = m_sel;
      t++;
    end
    cyc++;
    q.push_back(e);
  end

  always @(negedge clk) begin
    out_t e;
    if (q.size() == 0) begin
      errs++;
      $display("FAIL scoreboard: no expected entry at cycle %0d", cyc);
    end else begin
      e = q.pop_front();
      vecs++;
      if ({page_sel, digit_data, an} !== e) begin
        errs++;
        $display("FAIL scan cyc=%0d: sel/dig/an got %h/%h/%b want %h/%h/%b",
                 cyc, page_sel, digit_data, an, e.sel, e.dig, e.an);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // advance to the next negedge whose displayed frame position is d
  task automatic wait_disp(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((t - 1) % FR != d && n < 200);
    if ((t - 1) % FR != d) begin
      errs++;
      $display("FAIL timeout waiting for frame position %0d", d);
    end
  endtask

  // called at a negedge: acceptance lands 2 sync + DC debounce edges later
  task automatic press(input int hold);
    btn = 1'b1;
    pend = cyc + 1 + DC;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h1A3F, 16'hF3A1};
    tbl[1] = '{16'hC0DE, 16'hED0C};
    tbl[2] = '{16'h8421, 16'h1248};
    tbl[3] = '{16'h0F50, 16'h05F0};
    pg[0] = 16'h0000; pg[1] = 16'hABCD; pg[2] = 16'h5678; pg[3] = 16'h9E0C;
    // 1: reset
    repeat (3) @(negedge clk);
    chk("reset outputs", {6'd0, page_sel, digit_data, an}, 16'h000F);
    rst_n = 1'b1;
    wait_disp(0); chk("first blank", 16'(an), 16'hF);
    wait_disp(1); chk("first an0", 16'(an), 16'hE); chk("first digit", 16'(digit_data), 16'h0);
    wait_disp(7); chk("an0 held", 16'(an), 16'hE);
    wait_disp(8); chk("slot1 blank", 16'(an), 16'hF);
    wait_disp(9); chk("an1", 16'(an), 16'hD);
    // 2: scan order, table driven
    for (int i = 0; i < 4; i++) begin
      pg[0] = tbl[i].p;
      wait_disp(16);
      wait_disp(0);
      for (int k = 0; k < 4; k++) begin
        wait_disp(8 * k + 4);
        chk($sformatf("vec%0d digit%0d", i, k), 16'(digit_data), 16'(tbl[i].dig[15 - 4 * k -: 4]));
        chk($sformatf("vec%0d an%0d", i, k), 16'(an), 16'(an_seq[15 - 4 * k -: 4]));
      end
    end
    // 3: debounce
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch ignored", 16'(page_sel), 16'd0);
    press(20); chk("press 1", 16'(page_sel), 16'd1);
    press(20); chk("press 2", 16'(page_sel), 16'd2);
    press(20); chk("press 3", 16'(page_sel), 16'd3);
    press(20); chk("press wrap", 16'(page_sel), 16'd0);
    // 4: frame atomicity, increment lands exactly on the latch edge
    pg[0] = 16'h1234;
    wait_disp(16);
    wait_disp(0);
    wait_disp(25);
    btn = 1'b1;
    pend = cyc + 1 + DC;
    wait_disp(28); chk("atomic cur frame", 16'(digit_data), 16'h1);
    wait_disp(4);  chk("atomic next lo", 16'(digit_data), 16'h4); chk("sel after press", 16'(page_sel), 16'd1);
    wait_disp(28); chk("atomic next hi", 16'(digit_data), 16'h1);
    btn = 1'b0;
    wait_disp(4);  chk("new page lo", 16'(digit_data), 16'hD);
    wait_disp(28); chk("new page hi", 16'(digit_data), 16'hA);
    // 5: mid-scan reset in digit slot 2
    wait_disp(20);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midscan reset", {6'd0, page_sel, digit_data, an}, 16'h000F);
    pg[0] = 16'h0000;
    wait_disp(1); chk("restart an0", 16'(an), 16'hE); chk("restart shadow", 16'(digit_data), 16'h0);
    // 6: page data present only on the latch edge
    wait_disp(16);
    wait_disp(0);
    wait_disp(12); chk("pre-latch zero", 16'(digit_data), 16'h0);
    wait_disp(30);
    pg[0] = 16'hFFFF;
    @(negedge clk);
    pg[0] = 16'h0000;
    wait_disp(4);  chk("latch edge d0", 16'(digit_data), 16'hF);
    wait_disp(28); chk("latch edge d3", 16'(digit_data), 16'hF);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
